// File: rtl/imem_fetch_ctrl_if.sv
// Fetch controller port bundle: loader, redirect, decode handshake and memory port.
// master = core/memory side, slave = fetch controller.
interface imem_fetch_ctrl_if #(
  parameter int WIDTH1 = 32
) ();
  logic              run;
  logic              ld_valid;
  logic [WIDTH1-1:0] ld_addr;
  logic [WIDTH1-1:0] ld_data;
  logic              ld_ready;
  logic              redirect;
  logic [WIDTH1-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH1-1:0] out_pc;
  logic [WIDTH1-1:0] out_instr;
  logic [WIDTH1-1:0] mem_addr;
  logic              mem_wr;
  logic [WIDTH1-1:0] mem_wdata;
  logic [WIDTH1-1:0] mem_rdata;

  modport master (
    output run, ld_valid, ld_addr, ld_data, redirect, redirect_pc, out_ready, mem_rdata,
    input  ld_ready, out_valid, out_pc, out_instr, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  run, ld_valid, ld_addr, ld_data, redirect, redirect_pc, out_ready, mem_rdata,
    output ld_ready, out_valid, out_pc, out_instr, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer over a single-port memory; loader writes take the port first.
// Read-to-out_valid latency 2 cycles; 2-entry queue, issue stalls when queue + in-flight would overflow.
module imem_fetch_ctrl #(
  parameter int                WIDTH1   = 32,
  parameter int                MEM_SIZE = 1024,
  parameter logic [WIDTH1-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  imem_fetch_ctrl_if.slave bus
);

  typedef struct packed {
    logic [WIDTH1-1:0] pc;
    logic [WIDTH1-1:0] instr;
  } entry_t;

  localparam logic [WIDTH1-3:0] LAST_IDX = (WIDTH1-2)'(MEM_SIZE - 1);

  logic [WIDTH1-1:0] pc;
  logic [WIDTH1-1:0] pc_next;
  logic [WIDTH1-1:0] inflight_pc;
  logic              inflight;
  logic [1:0]        count;
  entry_t            q [2];
  entry_t            arriving;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic              unused_rpc_lsb;

  assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

  assign pop      = bus.out_valid & bus.out_ready;
  assign push     = inflight & ~bus.redirect;
  assign arriving = {inflight_pc, bus.mem_rdata};

  // Occupancy after this cycle's pop, plus the read we'd like to issue, must fit in 2.
  assign occ   = {1'b0, count} + {2'b00, inflight} + 3'd1;
  assign issue = bus.run & ~bus.ld_valid & ~bus.redirect & ~reset & (occ <= {2'b01, pop});

  assign pc_next = (pc[WIDTH1-1:2] == LAST_IDX) ? '0 : pc + WIDTH1'(4);

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = q[0].pc;
  assign bus.out_instr = q[0].instr;

  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = pc >> 2;
    bus.mem_wdata = '0;
    if (bus.ld_valid && !reset) begin
      bus.ld_ready  = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      q[0]        <= '0;
      q[1]        <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end

      if (bus.redirect) begin
        pc <= {bus.redirect_pc[WIDTH1-1:2], 2'b00};
      end else if (issue) begin
        pc <= pc_next;
      end

      // Entry 0 is always the head; a pop shifts entry 1 down.
      if (bus.redirect) begin
        count <= 2'd0;
        q[0]  <= '0;
        q[1]  <= '0;
      end else if (pop) begin
        q[0]  <= (push && count == 2'd1) ? arriving : q[1];
        if (push && count == 2'd2) begin
          q[1] <= arriving;
        end
        count <= count - 2'd1 + {1'b0, push};
      end else if (push) begin
        if (count == 2'd0) begin
          q[0] <= arriving;
        end else begin
          q[1] <= arriving;
        end
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed program scenarios, then randomized traffic checked every cycle
// against a queue-based model of the fetch stream.
module tb_imem_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  imem_fetch_ctrl_if #(.WIDTH1(32)) bus ();
  imem_fetch_ctrl_if #(.WIDTH1(32)) b2 ();

  imem_fetch_ctrl #(.WIDTH1(32), .MEM_SIZE(1024), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  imem_fetch_ctrl #(.WIDTH1(32), .MEM_SIZE(1024), .RESET_PC(32'hFFC)) dut_hi (
    .clk(clk), .reset(reset), .bus(b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0000_1011);
  endfunction

  // Instruction memory seen by the main instance: unwritten words read the pattern.
  logic [31:0] mem   [1024];
  bit          wrote [1024];
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_addr[9:0]]   <= bus.mem_wdata;
      wrote[bus.mem_addr[9:0]] <= 1'b1;
    end
    bus.mem_rdata <= wrote[bus.mem_addr[9:0]] ? mem[bus.mem_addr[9:0]] : pat(int'(bus.mem_addr[9:0]));
  end

  // Second instance only needs a recognisable read value per address.
  assign b2.run         = bus.run;
  assign b2.ld_valid    = 1'b0;
  assign b2.ld_addr     = '0;
  assign b2.ld_data     = '0;
  assign b2.redirect    = 1'b0;
  assign b2.redirect_pc = '0;
  assign b2.out_ready   = 1'b1;
  always @(posedge clk) b2.mem_rdata <= b2.mem_addr + 32'h1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] refmem [1024];
  ent_t        mq [$];
  bit          m_known;
  bit          m_after_rst;
  bit          m_inf;
  ent_t        m_inf_e;
  logic [31:0] m_pc;

  initial begin
    bit          exp_valid;
    bit          ld_now;
    bit          pop;
    bit          issue;
    int          occ;
    m_known = 0;
    for (int i = 0; i < 1024; i++) refmem[i] = pat(i);
    forever begin
      @(negedge clk);
      exp_valid = (mq.size() != 0);
      ld_now    = bus.ld_valid && !reset;
      if (m_known) begin
        chk("mdl_out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
          chk("mdl_out_pc", bus.out_pc, mq[0].pc);
          chk("mdl_out_instr", bus.out_instr, mq[0].instr);
        end else if (m_after_rst) begin
          chk("mdl_rst_out_pc", bus.out_pc, 32'h0);
          chk("mdl_rst_out_instr", bus.out_instr, 32'h0);
        end
        chk("mdl_ld_ready", bus.ld_ready, ld_now);
        chk("mdl_mem_wr", bus.mem_wr, ld_now);
        chk("mdl_mem_addr", bus.mem_addr, ld_now ? bus.ld_addr : (m_pc >> 2));
        chk("mdl_mem_wdata", bus.mem_wdata, ld_now ? bus.ld_data : 32'h0);
      end

      pop   = exp_valid && bus.out_ready;
      occ   = mq.size() + int'(m_inf) - int'(pop) + 1;
      issue = bus.run && !bus.ld_valid && !bus.redirect && !reset && (occ <= 2);
      if (reset) begin
        mq.delete();
        m_inf       = 0;
        m_pc        = 32'h0;
        m_known     = 1;
        m_after_rst = 1;
      end else if (m_known) begin
        if (pop) void'(mq.pop_front());
        if (bus.redirect) begin
          mq.delete();
          m_inf = 0;
          m_pc  = {bus.redirect_pc[31:2], 2'b00};
        end else begin
          if (m_inf) begin
            mq.push_back(m_inf_e);
            m_after_rst = 0;
          end
          m_inf = issue;
          if (issue) begin
            m_inf_e = '{pc: m_pc, instr: refmem[m_pc[11:2]]};
            m_pc    = (m_pc[31:2] == 30'd1023) ? 32'h0 : m_pc + 32'd4;
          end
        end
        if (bus.ld_valid) refmem[bus.ld_addr[9:0]] = bus.ld_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] prog [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input bit rdy);
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.run       = 1'b1;
    bus.out_ready = rdy;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193;
    reset           = 1'b1;
    bus.run         = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    tick();
    tick();

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_ld_ready", bus.ld_ready, 1'b0);
    chk("rst_mem_wr", bus.mem_wr, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_hi_mem_addr", b2.mem_addr, 32'h3FF);
    chk("rst_hi_ld_ready", b2.ld_ready, 1'b0);
    chk("rst_hi_mem_wr", b2.mem_wr, 1'b0);
    chk("rst_hi_mem_wdata", b2.mem_wdata, 32'h0);
    tick();

    // Load the program with fetch disabled.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'(i);
      bus.ld_data  = prog[i];
      @(negedge clk);
      chk("load_ld_ready", bus.ld_ready, 1'b1);
      chk("load_mem_addr", bus.mem_addr, 32'(i));
      tick();
    end
    bus.ld_valid = 1'b0;

    // Streaming: first word two cycles after the first issue opportunity.
    restart(1'b1);
    @(negedge clk); chk("s_valid_c0", bus.out_valid, 1'b0); tick();
    @(negedge clk); chk("s_valid_c1", bus.out_valid, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s_valid", bus.out_valid, 1'b1);
      chk("s_pc", bus.out_pc, 32'(4 * k));
      chk("s_instr", bus.out_instr, prog[k]);
      if (k == 0) begin
        chk("hi_pc0", b2.out_pc, 32'hFFC);
        chk("hi_instr0", b2.out_instr, 32'h13FF);
      end
      if (k == 1) begin
        chk("hi_valid1", b2.out_valid, 1'b1);
        chk("hi_pc1", b2.out_pc, 32'h0);
        chk("hi_instr1", b2.out_instr, 32'h1000);
      end
      tick();
    end

    // Stall: head held for 5 cycles, then drain in order.
    restart(1'b0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_pc", bus.out_pc, 32'h0);
      chk("stall_instr", bus.out_instr, prog[0]);
      if (k == 4) chk("stall_no_read", bus.mem_addr, 32'h2);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_pc", bus.out_pc, 32'(4 * k));
      chk("drain_instr", bus.out_instr, prog[k]);
      tick();
    end

    // Redirect with a full queue.
    restart(1'b0);
    tick(); tick(); tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h23;
    tick();
    bus.redirect = 1'b0;
    @(negedge clk); chk("redir_gap1", bus.out_valid, 1'b0); tick();
    @(negedge clk); chk("redir_gap2", bus.out_valid, 1'b0); tick();
    @(negedge clk);
    chk("redir_valid", bus.out_valid, 1'b1);
    chk("redir_pc", bus.out_pc, 32'h20);
    chk("redir_instr", bus.out_instr, pat(8));
    tick();

    // Loader pulse in the middle of streaming.
    bus.out_ready = 1'b1;
    tick(); tick();
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'd100;
    bus.ld_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ldp_ready", bus.ld_ready, 1'b1);
    chk("ldp_mem_wr", bus.mem_wr, 1'b1);
    chk("ldp_mem_addr", bus.mem_addr, 32'd100);
    chk("ldp_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    bus.ld_valid = 1'b0;
    tick(); tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h190;
    tick();
    bus.redirect = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("ldp_readback_pc", bus.out_pc, 32'h190);
    chk("ldp_readback", bus.out_instr, 32'hDEAD_BEEF);
    tick();

    // Wrap at the last memory word.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFE;
    tick();
    bus.redirect = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("wrap_pc_hi", bus.out_pc, 32'hFFC);
    chk("wrap_instr_hi", bus.out_instr, pat(1023));
    tick();
    @(negedge clk);
    chk("wrap_pc_lo", bus.out_pc, 32'h0);
    chk("wrap_instr_lo", bus.out_instr, prog[0]);
    tick();

    // Reset mid-stream.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk); chk("midrst_valid", bus.out_valid, 1'b0); tick();
    tick();
    @(negedge clk);
    chk("midrst_first_valid", bus.out_valid, 1'b1);
    chk("midrst_first_pc", bus.out_pc, 32'h0);
    tick();

    // Randomized traffic, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 199) == 0);
      bus.run         = ($urandom_range(0, 7) != 0);
      bus.ld_valid    = ($urandom_range(0, 9) == 0);
      bus.ld_addr     = 32'($urandom_range(0, 1023));
      bus.ld_data     = $urandom;
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = 32'($urandom_range(0, 4095));
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    bus.redirect = 1'b0;
    tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller that sequences the single-port instruction memory for the core. It owns the memory's address and write-enable lines and shares the port between a program loader (write path, priority) and the PC-driven fetch stream (read path). Fetched words are buffered in a 2-entry output queue with a valid/ready handshake toward decode. Branch/jump redirects flush all queued and in-flight fetches.

## Interface
- WIDTH1, 32, data/address width
- MEM_SIZE, 1024, words in instruction memory (power of two)
- RESET_PC, 0, byte address fetched first after reset (word aligned)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  fetch enable; 0 = no new reads issued
- ld_valid  in  1  loader write request
- ld_addr  in  WIDTH1  loader word index
- ld_data  in  WIDTH1  loader write data
- ld_ready  out  1  loader request accepted this cycle
- redirect  in  1  load new PC, flush queue and in-flight read
- redirect_pc  in  WIDTH1  new byte PC; bits [1:0] ignored (forced 00)
- out_valid  out  1  out_pc/out_instr hold a fetched word
- out_ready  in  1  decode accepts the head word
- out_pc  out  WIDTH1  byte PC of head word
- out_instr  out  WIDTH1  instruction of head word
- mem_addr  out  WIDTH1  word index to memory
- mem_wr  out  1  memory write enable
- mem_wdata  out  WIDTH1  memory write data
- mem_rdata  in  WIDTH1  registered memory read data (valid the cycle after a read)

## Operation
- State: pc (byte), queue (2 entries {pc, instr}, count 0..2), inflight bit + inflight_pc (read issued last cycle).
- Port mux (combinational from state/inputs): ld_valid=1 -> mem_wr=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_ready=1. Else mem_wr=0, mem_addr=pc>>2, mem_wdata=0, ld_ready=0. During reset ld_ready=0, mem_wr=0.
- pop = out_valid & out_ready.
- issue = run & ~ld_valid & ~redirect & ~reset & (count + inflight - pop + 1 <= 2).
- On issue: inflight<=1, inflight_pc<=pc, pc<=next(pc). Else inflight<=0.
- next(pc): word index (pc>>2)==MEM_SIZE-1 -> 0, else pc+4.
- Cycle with inflight=1 and no redirect: push {inflight_pc, mem_rdata} to queue tail at clock edge.
- Push and pop same cycle: both take effect; count unchanged.
- Redirect: pc<={redirect_pc[WIDTH1-1:2],2'b00}; queue cleared; inflight<=0 (arriving mem_rdata discarded); a pop in the same cycle still completes. Loader write in same cycle still performed.
- out_valid = count!=0; out_pc/out_instr = queue head; head stable while out_valid & ~out_ready.
- Reset: pc<=RESET_PC, count<=0, inflight<=0, queue contents <=0. Outputs after reset: out_valid=0, out_pc=0, out_instr=0, ld_ready=0, mem_wr=0, mem_wdata=0, mem_addr=RESET_PC>>2. Reset overrides every other input, including mid-stream.

## Timing
- Read issued in cycle t; mem_rdata valid in t+1; pushed at end of t+1; out_valid earliest in t+2.
- First cycle after reset with run=1: read of RESET_PC issued; out_valid in cycle 2.
- Throughput: 1 word/cycle with out_ready held high and no loader traffic.
- Loader write: one cycle, ld_ready same cycle; blocks fetch issue that cycle only.
- Redirect at cycle t: read of new PC issued t+1 (if run), out_valid t+3; no stale word visible from t+1.
- Never more than 2 words queued + in flight beyond capacity; no drop, no duplication.

## Test plan
- Reset, run=0; load words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; run=1, out_ready=1 -> out_valid from cycle 2, out_pc 0x0,0x4,0x8,0xC with matching instrs, one per cycle.
- Same program, out_ready=0 for 5 cycles from first out_valid -> out_pc=0x0/out_instr=0x00000013 stable, count reaches 2, no further reads; out_ready=1 -> 0x4,0x8,0xC follow, none lost or repeated.
- Queue full (pc 0x0,0x4), redirect_pc=0x23 -> out_valid low 2 cycles, next word out_pc=0x20 with imem[8]; 0x0/0x4 never accepted after redirect.
- run=1 streaming, ld_valid pulse (addr 100, data 0xDEADBEEF) -> ld_ready=1, mem_wr=1 that cycle, fetch stream continues in pc order with a one-word bubble; imem[100] reads back 0xDEADBEEF.
- RESET_PC=0xFFC, MEM_SIZE=1024 -> out_pc 0xFFC then 0x000.
- reset asserted with queue full and read in flight -> next cycle out_valid=0; after release first out_pc=RESET_PC.
